// File: rtl/hist_update_master_pkg.sv
// Shared types and helpers for the histogram read-modify-write initiator.
package hist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        CLR_WR
    } hist_state_e;

    localparam int          WORD_BYTES = 4;
    localparam logic [31:0] BIN_MAX    = 32'hFFFF_FFFF;

    // Bins stick at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == BIN_MAX) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hist_update_master_if.sv
// Avalon-MM initiator bus between the histogram updater and the word-addressed RAM slave.
interface hist_update_master_if;
   logic [31:0] m_address;
   logic        m_read;
   logic        m_write;
   logic [31:0] m_writedata;
   logic [3:0]  m_byteenable;
   logic        m_waitrequest;
   logic [31:0] m_readdata;
   logic        m_readdatavalid;

   modport master (
      output m_address, m_read, m_write, m_writedata, m_byteenable,
      input  m_waitrequest, m_readdata, m_readdatavalid
   );

   modport slave (
      input  m_address, m_read, m_write, m_writedata, m_byteenable,
      output m_waitrequest, m_readdata, m_readdatavalid
   );
endinterface

// File: rtl/hist_update_master.sv
// Histogram bin incrementer: read, saturating +1, write back; one transaction in flight.
// Also runs a full zero sweep on clear_req once any in-flight increment has retired.
module hist_update_master #(
   parameter int          BIN_W     = 12,
   parameter logic [31:0] BASE_ADDR = 32'h0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                bin_valid,
   input  logic [BIN_W-1:0]    bin_idx,
   output logic                bin_ready,
   input  logic                clear_req,
   output logic                clear_done,
   hist_update_master_if.master bus,
   output logic                busy,
   output logic [31:0]         upd_count,
   output logic                sat_flag
);
   import hist_pkg::*;

   hist_state_e      state_q, state_d;
   logic [BIN_W-1:0] bin_q;
   logic [BIN_W-1:0] clr_idx_q;
   logic [31:0]      rd_q;
   logic             clear_pend_q;
   logic             clear_done_q;
   logic             alive_q;
   logic [31:0]      upd_count_q;
   logic             sat_q;

   logic             bin_take;
   logic             rd_load;
   logic             inc_done;
   logic             clr_step;
   logic             clr_last;

   function automatic logic [31:0] word_addr(input logic [BIN_W-1:0] idx);
      return BASE_ADDR + (32'(idx) * 32'(WORD_BYTES));
   endfunction

   // alive_q keeps bin_ready low while reset is held and for the release edge.
   assign bin_ready    = alive_q && (state_q == IDLE) && !clear_pend_q && !clear_req;
   assign busy         = (state_q != IDLE) || clear_pend_q;
   assign clear_done   = clear_done_q;
   assign upd_count    = upd_count_q;
   assign sat_flag     = sat_q;
   assign bus.m_byteenable = 4'hF;

   always_comb begin
      state_d         = state_q;
      bus.m_read      = 1'b0;
      bus.m_write     = 1'b0;
      bus.m_address   = 32'h0;
      bus.m_writedata = 32'h0;
      bin_take        = 1'b0;
      rd_load         = 1'b0;
      inc_done        = 1'b0;
      clr_step        = 1'b0;
      clr_last        = 1'b0;
      case (state_q)
         IDLE: begin
            if (clear_pend_q) begin
               state_d = CLR_WR;
            end else if (bin_valid && bin_ready) begin
               bin_take = 1'b1;
               state_d  = RD_REQ;
            end
         end
         RD_REQ: begin
            bus.m_read    = 1'b1;
            bus.m_address = word_addr(bin_q);
            if (!bus.m_waitrequest) begin
               if (bus.m_readdatavalid) begin
                  rd_load = 1'b1;
                  state_d = WR_REQ;
               end else begin
                  state_d = RD_WAIT;
               end
            end
         end
         RD_WAIT: begin
            if (bus.m_readdatavalid) begin
               rd_load = 1'b1;
               state_d = WR_REQ;
            end
         end
         WR_REQ: begin
            bus.m_write     = 1'b1;
            bus.m_address   = word_addr(bin_q);
            bus.m_writedata = sat_inc(rd_q);
            if (!bus.m_waitrequest) begin
               inc_done = 1'b1;
               state_d  = IDLE;
            end
         end
         CLR_WR: begin
            bus.m_write   = 1'b1;
            bus.m_address = word_addr(clr_idx_q);
            if (!bus.m_waitrequest) begin
               clr_step = 1'b1;
               if (clr_idx_q == '1) begin
                  clr_last = 1'b1;
                  state_d  = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bin_q        <= '0;
         clr_idx_q    <= '0;
         rd_q         <= 32'h0;
         clear_pend_q <= 1'b0;
         clear_done_q <= 1'b0;
         alive_q      <= 1'b0;
         upd_count_q  <= 32'h0;
         sat_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         alive_q      <= 1'b1;
         clear_done_q <= clr_last;
         if (bin_take) bin_q <= bin_idx;
         if (rd_load)  rd_q  <= bus.m_readdata;
         if (inc_done) begin
            upd_count_q <= upd_count_q + 32'd1;
            if (rd_q == BIN_MAX) sat_q <= 1'b1;
         end
         // A clear_req arriving mid-sweep is dropped rather than restarting the sweep.
         if (clr_last) begin
            clear_pend_q <= 1'b0;
         end else if (clear_req && (state_q != CLR_WR)) begin
            clear_pend_q <= 1'b1;
         end
         if (state_q == IDLE && clear_pend_q) begin
            clr_idx_q <= '0;
         end else if (clr_step) begin
            clr_idx_q <= clr_idx_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hist_update_master.sv
// Bench for hist_update_master: behavioural RAM slave, write scoreboard, directed scenarios.
module tb_hist_update_master;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        bin_valid = 1'b0;
   logic [11:0] bin_idx = 12'h0;
   logic        bin_ready;
   logic        clear_req = 1'b0;
   logic        clear_done;
   logic        busy;
   logic [31:0] upd_count;
   logic        sat_flag;

   hist_update_master_if bus ();

   hist_update_master #(.BIN_W(12), .BASE_ADDR(32'h0)) dut (
      .clk(clk), .rst_n(rst_n), .bin_valid(bin_valid), .bin_idx(bin_idx),
      .bin_ready(bin_ready), .clear_req(clear_req), .clear_done(clear_done),
      .bus(bus.master), .busy(busy), .upd_count(upd_count), .sat_flag(sat_flag)
   );

   always #5 clk = ~clk;

   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;
   logic [31:0] mem     [0:4095];
   logic [31:0] ref_mem [0:4095];
   logic [63:0] exp_q [$];

   // slave controls
   bit          lat0 = 1'b0, stall_en = 1'b0, hold_wr = 1'b0;
   logic        wreq = 1'b0;
   bit          rd_acc = 1'b0;
   logic [11:0] rd_word = 12'h0;
   bit          p0v = 1'b0, p1v = 1'b0;
   logic [31:0] p0d = 32'h0, p1d = 32'h0;

   // monitor observations
   bit          prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
   logic [65:0] prev_cmd = '0;
   int          rd_start_cyc = 0, wr_start_cyc = 0, last_wr_cyc = 0;
   logic [31:0] rd_start_addr = 32'h0;
   int          n_writes = 0, done_pulses = 0, done_gap = 0;

   assign bus.m_waitrequest   = wreq | (hold_wr & bus.m_write);
   assign bus.m_readdatavalid = lat0 ? (bus.m_read & ~bus.m_waitrequest) : p1v;
   assign bus.m_readdata      = lat0 ? mem[bus.m_address[13:2]] : p1d;

   always @(posedge clk) cyc = cyc + 1;

   // Slave: read data returns two cycles after the accepted read; stalls drawn per cycle.
   always @(posedge clk) begin
      #1;
      p1v = p0v;
      p1d = p0d;
      p0v = rd_acc;
      p0d = mem[rd_word];
      wreq = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0; rd_acc = 1'b0;
      end else begin
         checks++;
         if (bus.m_read && bus.m_write) begin
            errors++;
            $display("FAIL rw_excl at cycle %0d: read=%b write=%b, required not both", cyc, bus.m_read, bus.m_write);
         end
         if (prev_stall) begin
            checks++;
            if ({bus.m_read, bus.m_write, bus.m_address, bus.m_writedata} !== prev_cmd) begin
               errors++;
               $display("FAIL stall_stable at cycle %0d: actual=%h required=%h", cyc,
                        {bus.m_read, bus.m_write, bus.m_address, bus.m_writedata}, prev_cmd);
            end
         end
         prev_stall = (bus.m_read || bus.m_write) && bus.m_waitrequest;
         prev_cmd   = {bus.m_read, bus.m_write, bus.m_address, bus.m_writedata};
         if (bus.m_read && !prev_rd) begin rd_start_cyc = cyc; rd_start_addr = bus.m_address; end
         if (bus.m_write && !prev_wr) wr_start_cyc = cyc;
         prev_rd = bus.m_read;
         prev_wr = bus.m_write;
         rd_acc  = bus.m_read && !bus.m_waitrequest;
         rd_word = bus.m_address[13:2];
         if (bus.m_write && !bus.m_waitrequest) begin
            mem[bus.m_address[13:2]] = bus.m_writedata;
            last_wr_cyc = cyc;
            n_writes++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL wr_unexpected: addr=%h data=%h, required no write", bus.m_address, bus.m_writedata);
            end else begin
               logic [63:0] e;
               e = exp_q.pop_front();
               if ({bus.m_address, bus.m_writedata} !== e) begin
                  errors++;
                  $display("FAIL wr_txn: addr=%h data=%h, required addr=%h data=%h",
                           bus.m_address, bus.m_writedata, e[63:32], e[31:0]);
               end
            end
         end
         if (clear_done) begin
            done_pulses++;
            done_gap = cyc - last_wr_cyc;
         end
      end
   end

   function automatic logic [31:0] inc_model(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_outputs", {bus.m_read, bus.m_write, busy, sat_flag, clear_done, bin_ready}, 32'h0);
      chk("rst_addr", bus.m_address, 32'h0);
      chk("rst_wdata", bus.m_writedata, 32'h0);
      chk("rst_be", 32'(bus.m_byteenable), 32'hF);
      chk("rst_upd", upd_count, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rdy_after_rst", 32'(bin_ready), 32'h1);
   endtask

   task automatic issue_bin(input int idx, input bit push, output int acc);
      int n = 0;
      @(negedge clk);
      bin_valid = 1'b1;
      bin_idx   = 12'(idx);
      while (!bin_ready && n < 200) begin @(negedge clk); n++; end
      if (!bin_ready) begin
         errors++; checks++;
         $display("FAIL bin_accept_timeout: bin %0d not accepted in 200 cycles", idx);
         bin_valid = 1'b0;
         acc = -1;
         return;
      end
      acc = cyc;
      if (push) begin
         ref_mem[idx] = inc_model(ref_mem[idx]);
         exp_q.push_back({32'(idx * 4), ref_mem[idx]});
      end
      @(posedge clk);
      #1 bin_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && n < 10000) begin @(negedge clk); n++; end
      if (busy || exp_q.size() != 0) begin
         errors++; checks++;
         $display("FAIL idle_timeout: busy=%b pending=%0d, required idle", busy, exp_q.size());
      end
   endtask

   initial begin
      int t1, t2, base, wr0, bad;
      for (int i = 0; i < 4096; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end

      // zero-stall back-to-back increments of bin 5
      do_reset();
      issue_bin(5, 1'b1, t1);
      issue_bin(5, 1'b1, t2);
      wait_idle();
      chk("rd_addr_bin5", rd_start_addr, 32'h14);
      chk("rd_at_t1", 32'(rd_start_cyc - t2), 32'd1);
      chk("wr_at_t4", 32'(wr_start_cyc - t2), 32'd4);
      chk("throughput_5", 32'(t2 - t1), 32'd5);
      chk("upd_count_2", upd_count, 32'd2);
      chk("mem5", mem[5], 32'd2);

      // saturation on an all-ones bin
      do_reset();
      mem[7] = 32'hFFFF_FFFF;
      ref_mem[7] = 32'hFFFF_FFFF;
      issue_bin(7, 1'b1, t1);
      wait_idle();
      chk("sat_set", 32'(sat_flag), 32'h1);
      chk("upd_count_sat", upd_count, 32'd1);
      issue_bin(8, 1'b1, t1);
      issue_bin(9, 1'b1, t1);
      wait_idle();
      chk("sat_sticky", 32'(sat_flag), 32'h1);
      chk("upd_count_3", upd_count, 32'd3);
      chk("mem7", mem[7], 32'hFFFF_FFFF);

      // slave returns data in the read-accept cycle
      lat0 = 1'b1;
      issue_bin(20, 1'b1, t1);
      issue_bin(20, 1'b1, t2);
      wait_idle();
      chk("zl_turnaround", 32'(t2 - t1), 32'd3);
      chk("zl_wr_at_t2", 32'(wr_start_cyc - t2), 32'd2);
      chk("zl_mem20", mem[20], 32'd2);
      lat0 = 1'b0;

      // random stalls over 100 bins against the reference array
      base = int'(upd_count);
      stall_en = 1'b1;
      for (int i = 0; i < 100; i++) issue_bin(int'($urandom_range(0, 31)), 1'b1, t1);
      wait_idle();
      stall_en = 1'b0;
      for (int i = 0; i < 32; i++) chk($sformatf("rand_mem%0d", i), mem[i], ref_mem[i]);
      chk("rand_upd", upd_count, 32'(base + 100));

      // clear requested while bin 3 waits for read data
      do_reset();
      done_pulses = 0;
      wr0 = n_writes;
      issue_bin(3, 1'b1, t1);
      @(posedge clk);
      #1 clear_req = 1'b1;
      for (int i = 0; i < 4096; i++) begin
         exp_q.push_back({32'(i * 4), 32'h0});
         ref_mem[i] = 32'h0;
      end
      @(posedge clk);
      #1 clear_req = 1'b0;
      bad = 0;
      for (int n = 0; n < 6000 && exp_q.size() != 0; n++) begin
         @(negedge clk);
         if (bin_ready && exp_q.size() != 0) bad++;
         if (n == 1000) clear_req = 1'b1;
         if (n == 1001) clear_req = 1'b0;
      end
      repeat (5) @(negedge clk);
      chk("clr_pending_writes", 32'(exp_q.size()), 32'd0);
      chk("clr_rdy_low", 32'(bad), 32'd0);
      chk("clr_write_total", 32'(n_writes - wr0), 32'd4097);
      chk("clr_done_pulses", 32'(done_pulses), 32'd1);
      chk("clr_done_gap", 32'(done_gap), 32'd1);
      chk("clr_upd_kept", upd_count, 32'd1);
      chk("clr_idle", {31'h0, busy}, 32'h0);
      chk("clr_rdy_back", 32'(bin_ready), 32'h1);

      // reset while the write is stalled: bin is dropped, next bin behaves
      do_reset();
      hold_wr = 1'b1;
      issue_bin(11, 1'b0, t1);
      for (int n = 0; n < 20 && !bus.m_write; n++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("stalled_write", 32'(bus.m_write), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("arst_outputs", {bus.m_read, bus.m_write, busy, sat_flag, clear_done, bin_ready}, 32'h0);
      chk("arst_addr", bus.m_address, 32'h0);
      chk("arst_wdata", bus.m_writedata, 32'h0);
      chk("arst_upd", upd_count, 32'h0);
      hold_wr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue_bin(11, 1'b1, t1);
      wait_idle();
      chk("post_rst_mem11", mem[11], 32'd1);
      chk("post_rst_upd", upd_count, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
